// File: rtl/icache_2way.sv
// 2-way set-associative read-only instruction cache, 128-bit lines, flop storage with async read.
// Latency: hit acks combinationally in the request cycle; miss acks N+1 cycles later (N = memory stb cycles).
// Backpressure: cpu_ack is withheld for the whole fill; write requests and cycles carrying inv get no ack.
module icache_2way #(
    parameter int IDX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [11:0]  cpu_adr,
    input  logic         cpu_cyc,
    input  logic         cpu_stb,
    input  logic         cpu_we,
    input  logic [15:0]  cpu_sel,
    output logic [127:0] cpu_dat_s,
    output logic         cpu_ack,
    output logic [11:0]  mem_adr,
    output logic         mem_cyc,
    output logic         mem_stb,
    output logic         mem_we,
    output logic [15:0]  mem_sel,
    input  logic [127:0] mem_dat_s,
    input  logic         mem_ack,
    input  logic         inv,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = 12 - IDX_W;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t             state;
    logic [SETS-1:0]    valid0;
    logic [SETS-1:0]    valid1;
    logic [SETS-1:0]    lru;
    logic [TAG_W-1:0]   tag0  [SETS];
    logic [TAG_W-1:0]   tag1  [SETS];
    logic [127:0]       data0 [SETS];
    logic [127:0]       data1 [SETS];
    logic [11:0]        fill_adr;
    logic [15:0]        hit_q;
    logic [15:0]        miss_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic               miss;
    logic               fill_done;
    logic               victim_way;

    // Byte selects carry no meaning for whole-line instruction fetches.
    logic unused_sel;
    assign unused_sel = ^cpu_sel;

    assign idx      = cpu_adr[IDX_W-1:0];
    assign tag      = cpu_adr[11:IDX_W];
    assign fill_idx = fill_adr[IDX_W-1:0];
    assign fill_tag = fill_adr[11:IDX_W];

    // Tag lookup; a cycle carrying inv does no lookup at all, so it neither acks nor starts a fill.
    always_comb begin
        lookup     = (state == S_IDLE) && cpu_cyc && cpu_stb && !cpu_we && !inv;
        hit0       = valid0[idx] && (tag0[idx] == tag);
        hit1       = valid1[idx] && (tag1[idx] == tag);
        hit        = lookup && (hit0 || hit1);
        miss       = lookup && !(hit0 || hit1);
        fill_done  = (state == S_FILL) && mem_ack;
        // Invalid ways are filled first (way0 before way1), otherwise the LRU bit picks.
        if (!valid0[fill_idx]) begin
            victim_way = 1'b0;
        end else if (!valid1[fill_idx]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru[fill_idx];
        end
    end

    assign cpu_ack   = hit;
    assign cpu_dat_s = hit1 ? data1[idx] : data0[idx];
    assign mem_cyc   = (state == S_FILL);
    assign mem_stb   = (state == S_FILL);
    assign mem_adr   = fill_adr;
    assign mem_we    = 1'b0;
    assign mem_sel   = 16'hFFFF;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

    // Fill sequencer: latch the missing line address and hold it until memory acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fill_adr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        fill_adr <= cpu_adr;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid and LRU bookkeeping; inv wins over a coincident fill so that line stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            if (inv) begin
                valid0 <= '0;
                valid1 <= '0;
            end else if (fill_done) begin
                if (victim_way) begin
                    valid1[fill_idx] <= 1'b1;
                end else begin
                    valid0[fill_idx] <= 1'b1;
                end
            end
            if (hit) begin
                lru[idx] <= !hit1;
            end else if (fill_done) begin
                lru[fill_idx] <= !victim_way;
            end
        end
    end

    // Line payload and tag capture; gated by the FSM, so an aborted fill writes nothing.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            if (victim_way) begin
                data1[fill_idx] <= mem_dat_s;
                tag1[fill_idx]  <= fill_tag;
            end else begin
                data0[fill_idx] <= mem_dat_s;
                tag0[fill_idx]  <= fill_tag;
            end
        end
    end

    // Saturating hit/miss performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if (miss && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

endmodule
